fp_accum: RTL
=============

Name: fp_accum

Overview:
- Streaming IEEE-754 single-precision accumulator placed directly downstream of fp_mult.
- Consumes a packet of products over a valid/ready handshake and sums them with an iterative align/add/normalise datapath.
- Returns the packet sum and element count when the last element has been accumulated.
- Forms the reduction half of the dot-product path: fp_mult feeds it, and the result/writeback logic consumes it.

Parameters:
- DATA_WIDTH, 32, float word width; the sign is the MSB.
- EXP_WIDTH, 8, exponent field width; bias = 2^(EXP_WIDTH-1)-1.
- MAN_WIDTH, 23, stored mantissa field width.
- CNT_WIDTH, 16, element counter width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream product valid.
- in_ready  output  1  block can accept a product this cycle.
- in_data  input  DATA_WIDTH  product word from fp_mult.
- in_last  input  1  marks the final element of the packet; sampled with in_data.
- out_valid  output  1  packet sum available.
- out_ready  input  1  downstream accepts the sum.
- out_data  output  DATA_WIDTH  packet sum.
- out_count  output  CNT_WIDTH  number of elements accumulated in the packet.

Behaviour:
- Reset (rst=1 at a clock edge), applicable at any time including mid-packet or while DONE:
  - State goes to IDLE; accumulator = +0; count = 0; NaN flag = 0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, out_count=0.
- FSM states: IDLE, ALIGN, ADD, NORM, DONE.
- IDLE:
  - in_ready=1.
  - An accept is in_valid & in_ready at an edge: latch in_data and in_last, increment count (saturating at all-ones), go to ALIGN.
- ALIGN:
  - Unpack the operand and the accumulator.
  - exp==0 means zero; denormals are flushed to zero.
  - Attach the hidden bit and 3 guard bits.
  - Right-shift the smaller-exponent mantissa by the exponent difference. A difference >= MAN_WIDTH+4 makes it zero.
  - Go to ADD.
- ADD:
  - Same signs: add magnitudes.
  - Different signs: subtract smaller from larger; the result takes the larger operand's sign.
  - Go to NORM.
- NORM (single cycle, leading-zero count):
  - Carry-out: shift right 1, exp+1.
  - Otherwise: shift left by the leading-zero count, exp minus that count.
  - Rounding is truncation; guard bits are discarded.
  - Zero magnitude gives +0 (exact cancellation is +0).
  - exp >= 2^EXP_WIDTH-1 after normalising gives signed Inf.
  - exp <= 0 gives +0.
  - Write the result to the accumulator.
  - Latched in_last=1: go to DONE. Otherwise go to IDLE.
- Timing:
  - Accept at edge T: in_ready is 0 in cycles T+1..T+3; the accumulator is updated at edge T+3; in_ready is 1 again after T+3.
  - Throughput is 1 element per 4 cycles.
- Special inputs:
  - Any operand with exp all-ones and mantissa !=0, or Inf + opposite-sign Inf, sets the sticky NaN flag.
  - While the flag is set, the result is 32'h7fc00000.
  - Inf + same-sign Inf or finite gives Inf.
  - Accumulator Inf plus finite stays Inf.
- DONE:
  - out_valid=1; out_data and out_count are held stable while out_ready=0; in_ready=0.
  - On out_valid & out_ready: accumulator = +0, count = 0, NaN flag cleared, out_valid=0 next cycle, go to IDLE.
- The first element of a packet adds to +0, so it is returned exactly, apart from denormal flush.
- in_valid without an accept is ignored. in_data and in_last matter only on an accept.
- No output changes combinationally from inputs; all outputs are registered.

Test Plan:
- Single element 0x41b80000 with last=1 -> out_data=0x41b80000, out_count=1; out_valid rises 4 cycles after the accept.
- Packet 0x3f800000, 0x40000000 (last) -> out_data=0x40400000, out_count=2; in_ready low exactly 3 cycles after each accept.
- Packet 0x44816000 (23*45 product), 0x3f800000 (last) -> 0x44818000. Packet 0x40400000, 0xc0400000 (last) -> 0x00000000.
- Truncation/alignment:
  - 0x3f800000, 0x33800000 (last) -> 0x3f800000.
  - 0x7f800000, 0xff800000 (last) -> 0x7fc00000.
  - Following packet 0x3f800000 (last) -> 0x3f800000, showing the NaN flag cleared.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, out_data, out_count stable; in_ready=0; in_valid pulses ignored. Sum returned once out_ready=1, then IDLE.
- Reset mid-operation:
  - Assert rst in the ALIGN cycle of the 2nd element -> next cycle in_ready=1, out_valid=0.
  - New packet 0x40000000 (last) -> 0x40000000, count=1.

Source files
------------

// File: rtl/fp_accum.sv
// fp_accum: streaming IEEE-754 single-precision accumulator, one element per 4 cycles (accept/ALIGN/ADD/NORM).
// Sum and element count are held in DONE until taken by out_ready; in_ready stays low while busy or holding a result.
module fp_accum #(
  parameter int DATA_WIDTH = 32,
  parameter int EXP_WIDTH  = 8,
  parameter int MAN_WIDTH  = 23,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  out_count
);
  localparam int MW  = MAN_WIDTH + 4;
  localparam int EW2 = EXP_WIDTH + 2;
  localparam int LZW = $clog2(MW + 1);
  localparam logic [EXP_WIDTH-1:0]  EXP_ONES = '1;
  localparam logic [DATA_WIDTH-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;
  state_t r_state, w_state_nxt;

  logic [DATA_WIDTH-1:0] r_op, r_acc;
  logic                  r_last, r_nan;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [MW-1:0]         r_ma, r_mb;
  logic                  r_sa, r_sb, r_sign;
  logic [MW:0]           r_sum;
  logic [EW2-1:0]        r_exp;
  logic                  r_nan_new, r_inf, r_inf_sign;

  logic                  w_op_s, w_acc_s, w_acc_big, w_op_nan, w_op_inf, w_acc_inf;
  logic [EXP_WIDTH-1:0]  w_op_e, w_acc_e, w_big_e, w_diff;
  logic [MAN_WIDTH-1:0]  w_op_m, w_acc_m;
  logic [MW-1:0]         w_op_mx, w_acc_mx, w_small;

  always_comb begin
    {w_op_s, w_op_e, w_op_m}    = r_op;
    {w_acc_s, w_acc_e, w_acc_m} = r_acc;
    // exp==0 covers both zero and denormal: both treated as zero
    w_op_mx   = (w_op_e == '0) ? '0 : {1'b1, w_op_m, 3'b000};
    w_acc_mx  = (w_acc_e == '0) ? '0 : {1'b1, w_acc_m, 3'b000};
    w_acc_big = (w_acc_e >= w_op_e);
    w_big_e   = w_acc_big ? w_acc_e : w_op_e;
    w_diff    = w_acc_big ? (w_acc_e - w_op_e) : (w_op_e - w_acc_e);
    w_small   = w_acc_big ? w_op_mx : w_acc_mx;
    w_small   = (w_diff >= EXP_WIDTH'(MW)) ? '0 : (w_small >> w_diff);
    w_op_nan  = (w_op_e == EXP_ONES) && (w_op_m != '0);
    w_op_inf  = (w_op_e == EXP_ONES) && (w_op_m == '0);
    w_acc_inf = (w_acc_e == EXP_ONES) && (w_acc_m == '0);
  end

  logic [LZW-1:0]        w_lzc;
  logic                  w_found;
  logic [MAN_WIDTH-1:0]  w_frac;
  logic [EW2-1:0]        w_norm_e;
  logic [DATA_WIDTH-1:0] w_res;
  logic                  w_res_nan;

  always_comb begin
    w_lzc   = '0;
    w_found = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!w_found) begin
        if (r_sum[i]) w_found = 1'b1;
        else          w_lzc   = w_lzc + LZW'(1);
      end
    end
    if (r_sum[MW]) begin
      w_frac   = r_sum[MW-1:4];
      w_norm_e = r_exp + EW2'(1);
    end else begin
      w_frac   = MAN_WIDTH'((r_sum[MW-1:0] << w_lzc) >> 3);
      w_norm_e = r_exp - EW2'(w_lzc);
    end
    w_res_nan = r_nan || r_nan_new;
    if (w_res_nan)
      w_res = QNAN;
    else if (r_inf)
      w_res = {r_inf_sign, EXP_ONES, {MAN_WIDTH{1'b0}}};
    else if ((r_sum == '0) || w_norm_e[EW2-1] || (w_norm_e == '0))
      w_res = '0;
    else if (w_norm_e >= EW2'(EXP_ONES))
      w_res = {r_sign, EXP_ONES, {MAN_WIDTH{1'b0}}};
    else
      w_res = {r_sign, w_norm_e[EXP_WIDTH-1:0], w_frac};
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = S_ALIGN;
      S_ALIGN: w_state_nxt = S_ADD;
      S_ADD:   w_state_nxt = S_NORM;
      S_NORM:  w_state_nxt = r_last ? S_DONE : S_IDLE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  assign out_data  = r_acc;
  assign out_count = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_nan  <= 1'b0;
      r_op   <= '0;
      r_last <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid && in_ready) begin
          r_op   <= in_data;
          r_last <= in_last;
          if (r_cnt != '1) r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
        S_NORM: begin
          r_acc <= w_res;
          if (w_res_nan) r_nan <= 1'b1;
        end
        S_DONE: if (out_ready) begin
          r_acc <= '0;
          r_cnt <= '0;
          r_nan <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // datapath pipeline registers; only meaningful after ALIGN has loaded them
  always_ff @(posedge clk) begin
    case (r_state)
      S_ALIGN: begin
        r_ma       <= w_acc_big ? w_acc_mx : w_op_mx;
        r_mb       <= w_small;
        r_sa       <= w_acc_big ? w_acc_s : w_op_s;
        r_sb       <= w_acc_big ? w_op_s : w_acc_s;
        r_exp      <= EW2'(w_big_e);
        r_nan_new  <= w_op_nan || (w_op_inf && w_acc_inf && (w_op_s != w_acc_s));
        r_inf      <= w_op_inf || w_acc_inf;
        r_inf_sign <= w_op_inf ? w_op_s : w_acc_s;
      end
      S_ADD: begin
        if (r_sa == r_sb) begin
          r_sum  <= {1'b0, r_ma} + {1'b0, r_mb};
          r_sign <= r_sa;
        end else if (r_ma >= r_mb) begin
          r_sum  <= {1'b0, r_ma - r_mb};
          r_sign <= r_sa;
        end else begin
          r_sum  <= {1'b0, r_mb - r_ma};
          r_sign <= r_sb;
        end
      end
      default: ;
    endcase
  end
endmodule
